// File: rtl/bnn_pkg.sv
// Shared types and default geometry for the BNN host-side sequencer.
package bnn_pkg;

  localparam int I_CH           = 3;
  localparam int O_CH           = 64;
  localparam int OUT_ROW_LENGTH = 4;
  localparam int WIDTH          = 14;
  localparam int DW             = 9;
  localparam int ADDR_W         = 8;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int S         = I_CH * (O_CH + OUT_ROW_LENGTH);
  localparam int P         = O_CH * OUT_ROW_LENGTH;
  localparam int RES_IDX_W = cw(P);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_STREAM,
    ST_POP,
    ST_DONE
  } seq_state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic mem_en;
    logic arr_rst_n;
    logic load_weight;
    logic in_valid;
  } seq_ctl_t;

  localparam seq_ctl_t CTL_IDLE = '{busy: 1'b0, done: 1'b0, mem_en: 1'b0,
                                    arr_rst_n: 1'b1, load_weight: 1'b0,
                                    in_valid: 1'b0};

endpackage

// File: rtl/bnn_seq_cnt.sv
// Nested channel/element counter for the STREAM phase, exposing next values
// and terminal flags so the driver can register its outputs one cycle early.
module bnn_seq_cnt import bnn_pkg::*; #(
  parameter int N_CH = bnn_pkg::I_CH,
  parameter int N_EL = bnn_pkg::O_CH + bnn_pkg::OUT_ROW_LENGTH,
  localparam int EL_W = bnn_pkg::cw(N_EL)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            adv,
  output logic [EL_W-1:0] el_d,
  output logic            last_q,
  output logic            last_d
);

  localparam int CH_W = cw(N_CH);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [EL_W-1:0] EL_LAST = EL_W'(N_EL - 1);

  logic [CH_W-1:0] ch_q, ch_d;
  logic [EL_W-1:0] el_q;

  always_comb begin
    ch_d = ch_q;
    el_d = el_q;
    if (adv) begin
      if (el_q == EL_LAST) begin
        el_d = '0;
        ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else begin
        el_d = el_q + 1'b1;
      end
    end
  end

  assign last_q = (ch_q == CH_LAST) && (el_q == EL_LAST);
  assign last_d = (ch_d == CH_LAST) && (el_d == EL_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ch_q <= '0;
      el_q <= '0;
    end else begin
      ch_q <= ch_d;
      el_q <= el_d;
    end
  end

endmodule

// File: rtl/bnn_seq_driver.sv
// Host-side sequencer: clears the BNN array, streams weights/activations from a
// sync-read buffer, pops all psums and emits them as an indexed result stream.
// Optional macro BNN_SEQ_BACKPRESSURE_EN adds res_ready, which gates popping.
module bnn_seq_driver #(
  parameter int I_CH           = bnn_pkg::I_CH,
  parameter int O_CH           = bnn_pkg::O_CH,
  parameter int OUT_ROW_LENGTH = bnn_pkg::OUT_ROW_LENGTH,
  parameter int WIDTH          = bnn_pkg::WIDTH,
  parameter int DW             = bnn_pkg::DW,
  parameter int ADDR_W         = bnn_pkg::ADDR_W,
  localparam int IDX_W         = bnn_pkg::cw(O_CH * OUT_ROW_LENGTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
`ifdef BNN_SEQ_BACKPRESSURE_EN
  input  logic              res_ready,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic              arr_rst_n_out,
  output logic [DW-1:0]     data_out,
  output logic              load_weight_out,
  output logic              in_valid_out,
  output logic              pop_out,
  input  logic [WIDTH-1:0]  sum_in,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_data,
  output logic [IDX_W-1:0]  res_idx
);
  import bnn_pkg::*;

  localparam int EL_LEN  = O_CH + OUT_ROW_LENGTH;
  localparam int EL_W    = cw(EL_LEN);
  localparam int POP_LEN = O_CH * OUT_ROW_LENGTH;
  localparam logic [EL_W-1:0]  W_END    = EL_W'(O_CH);
  localparam logic [IDX_W-1:0] POP_LAST = IDX_W'(POP_LEN - 1);

  seq_state_t        state_q, state_d;
  seq_ctl_t          ctl_q, ctl_d;
  logic [IDX_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [EL_W-1:0]   el_d;
  logic              adv, last_q, last_d, pop_d;

  bnn_seq_cnt #(.N_CH(I_CH), .N_EL(EL_LEN)) u_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .adv    (adv),
    .el_d   (el_d),
    .last_q (last_q),
    .last_d (last_d)
  );

`ifdef BNN_SEQ_BACKPRESSURE_EN
  assign pop_out = (state_q == ST_POP) && res_ready;
`else
  logic pop_q;
  assign pop_out = pop_q;
`endif

  always_comb begin
    state_d   = state_q;
    pop_cnt_d = pop_cnt_q;
    adv       = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLR;
      ST_CLR:    state_d = ST_STREAM;
      ST_STREAM: begin
        adv = 1'b1;
        if (last_q) state_d = ST_POP;
      end
      ST_POP: if (pop_out) begin
        if (pop_cnt_q == POP_LAST) begin
          pop_cnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          pop_cnt_d = pop_cnt_q + 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from next-state/next-count values and then
  // registered, so each one lines up with the cycle it describes.
  always_comb begin
    ctl_d             = CTL_IDLE;
    ctl_d.busy        = (state_d != ST_IDLE);
    ctl_d.done        = (state_d == ST_DONE);
    ctl_d.arr_rst_n   = (state_d != ST_CLR);
    ctl_d.load_weight = (state_d == ST_STREAM) && (el_d < W_END);
    ctl_d.in_valid    = (state_d == ST_STREAM) && !(el_d < W_END);
    ctl_d.mem_en      = (state_d == ST_CLR) || ((state_d == ST_STREAM) && !last_d);
    addr_d            = ((state_d == ST_STREAM) && ctl_d.mem_en) ? mem_addr + 1'b1 : '0;
    pop_d             = (state_d == ST_POP);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      pop_cnt_q <= '0;
      ctl_q     <= CTL_IDLE;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state_q   <= state_d;
      pop_cnt_q <= pop_cnt_d;
      ctl_q     <= ctl_d;
      mem_addr  <= addr_d;
      res_valid <= pop_out;
      if (pop_out) begin
        res_data <= sum_in;
        res_idx  <= pop_cnt_q;
      end
    end
  end

`ifndef BNN_SEQ_BACKPRESSURE_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) pop_q <= 1'b0;
    else        pop_q <= pop_d;
  end
`else
  logic unused_pop_d;
  assign unused_pop_d = pop_d;
`endif

  assign busy            = ctl_q.busy;
  assign done            = ctl_q.done;
  assign mem_en          = ctl_q.mem_en;
  assign arr_rst_n_out   = ctl_q.arr_rst_n;
  assign load_weight_out = ctl_q.load_weight;
  assign in_valid_out    = ctl_q.in_valid;
  // NOTE: data_out is the only combinational output; the buffer word arrives a cycle after its address.
  assign data_out = (ctl_q.load_weight || ctl_q.in_valid) ? mem_rdata : '0;

endmodule

// File: tb/tb_bnn_seq_driver.sv
// Directed self-checking bench for bnn_seq_driver: default geometry plus a tiny
// I_CH=1/O_CH=2/OUT_ROW_LENGTH=1 instance, with a buffer model and array model.
module tb_bnn_seq_driver;

  localparam int S = 204;
  localparam int P = 256;
  localparam int E = 68;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic        rst_in = 1'b1;
  logic        start  = 1'b0;
  logic        res_ready = 1'b1;
  logic        busy, done, mem_en, arr_rst_n, lw, iv, pop, res_valid;
  logic [7:0]  mem_addr, res_idx;
  logic [8:0]  mem_rdata = '0;
  logic [8:0]  data_out;
  logic [13:0] sum_in, res_data;

  bnn_seq_driver u_dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .start           (start),
`ifdef BNN_SEQ_BACKPRESSURE_EN
    .res_ready       (res_ready),
`endif
    .busy            (busy),
    .done            (done),
    .mem_en          (mem_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .arr_rst_n_out   (arr_rst_n),
    .data_out        (data_out),
    .load_weight_out (lw),
    .in_valid_out    (iv),
    .pop_out         (pop),
    .sum_in          (sum_in),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .res_idx         (res_idx)
  );

  logic        s_start = 1'b0;
  logic        s_busy, s_done, s_mem_en, s_arr_rst_n, s_lw, s_iv, s_pop, s_res_valid;
  logic [7:0]  s_mem_addr;
  logic [8:0]  s_mem_rdata = '0;
  logic [8:0]  s_data_out;
  logic [13:0] s_sum_in, s_res_data;
  logic [0:0]  s_res_idx;

  bnn_seq_driver #(.I_CH(1), .O_CH(2), .OUT_ROW_LENGTH(1), .WIDTH(14), .DW(9), .ADDR_W(8)) u_small (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .start           (s_start),
`ifdef BNN_SEQ_BACKPRESSURE_EN
    .res_ready       (1'b1),
`endif
    .busy            (s_busy),
    .done            (s_done),
    .mem_en          (s_mem_en),
    .mem_addr        (s_mem_addr),
    .mem_rdata       (s_mem_rdata),
    .arr_rst_n_out   (s_arr_rst_n),
    .data_out        (s_data_out),
    .load_weight_out (s_lw),
    .in_valid_out    (s_iv),
    .pop_out         (s_pop),
    .sum_in          (s_sum_in),
    .res_valid       (s_res_valid),
    .res_data        (s_res_data),
    .res_idx         (s_res_idx)
  );

  // Buffer model: word k holds k, one-cycle read latency.
  always @(posedge clk) if (mem_en)   mem_rdata   <= 9'(mem_addr);
  always @(posedge clk) if (s_mem_en) s_mem_rdata <= 9'(s_mem_addr);

  // Array model: psum presented during a pop cycle equals the pop index.
  int arr_cnt = 0;
  int s_arr_cnt = 0;
  always @(posedge clk) begin
    if (rst_in || done) arr_cnt <= 0;
    else if (pop)       arr_cnt <= arr_cnt + 1;
    if (rst_in || s_done) s_arr_cnt <= 0;
    else if (s_pop)       s_arr_cnt <= s_arr_cnt + 1;
  end
  assign sum_in   = 14'(arr_cnt);
  assign s_sum_in = 14'(s_arr_cnt);

  wire [7:0] obs_v  = {busy, done, mem_en, arr_rst_n, lw, iv, pop, res_valid};
  wire [7:0] obs_sv = {s_busy, s_done, s_mem_en, s_arr_rst_n, s_lw, s_iv, s_pop, s_res_valid};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    n_chk++;
    if ({obs_v, mem_addr, data_out} !== {8'b0001_0000, 8'd0, 9'd0})
      $display("FAIL reset_state got %h want %h", {obs_v, mem_addr, data_out}, {8'b0001_0000, 8'd0, 9'd0});
    else n_pass++;
    n_chk++;
    if ({res_idx, res_data} !== 22'd0)
      $display("FAIL reset_result got %h want 0", {res_idx, res_data});
    else n_pass++;
    n_chk++;
    if (obs_sv !== 8'b0001_0000)
      $display("FAIL reset_small got %b want 00010000", obs_sv);
    else n_pass++;
    tick();
    n_chk++;
    if (obs_v !== 8'b0001_0000)
      $display("FAIL idle_hold got %b want 00010000", obs_v);
    else n_pass++;
  endtask

  task automatic run_full(input string tag);
    logic        lw_e;
    logic [24:0] e25, o25;
    logic [29:0] e30, o30;
    int          cyc, done_at;
    done_at = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    n_chk++;
    if ({obs_v, mem_addr} !== {8'b1010_0000, 8'd0})
      $display("FAIL %s clr got %h want %h", tag, {obs_v, mem_addr}, {8'b1010_0000, 8'd0});
    else n_pass++;
    for (int k = 0; k < S; k++) begin
      tick();
      cyc++;
      lw_e = (k % E) < 64;
      e25 = {1'b1, 1'b0, (k + 1 < S), 1'b1, lw_e, ~lw_e, 2'b00,
             8'((k + 1 < S) ? k + 1 : 0), 9'(k)};
      o25 = {obs_v, mem_addr, data_out};
      n_chk++;
      if (o25 !== e25) $display("FAIL %s stream k=%0d got %h want %h", tag, k, o25, e25);
      else n_pass++;
    end
    for (int i = 0; i < P; i++) begin
      tick();
      cyc++;
      n_chk++;
      if (i == 0) begin
        if (obs_v !== 8'b1001_0010) $display("FAIL %s pop0 got %b want 10010010", tag, obs_v);
        else n_pass++;
      end else begin
        e30 = {8'b1001_0011, 8'(i - 1), 14'(i - 1)};
        o30 = {obs_v, res_idx, res_data};
        if (o30 !== e30) $display("FAIL %s pop i=%0d got %h want %h", tag, i, o30, e30);
        else n_pass++;
      end
    end
    tick();
    cyc++;
    if (done) done_at = cyc;
    n_chk++;
    if ({obs_v, res_idx, res_data} !== {8'b1101_0001, 8'd255, 14'd255})
      $display("FAIL %s done_cycle got %h want %h", tag, {obs_v, res_idx, res_data},
               {8'b1101_0001, 8'd255, 14'd255});
    else n_pass++;
    n_chk++;
    if (done_at !== 462) $display("FAIL %s done_latency got %0d want 462", tag, done_at);
    else n_pass++;
    tick();
    n_chk++;
    if (obs_v !== 8'b0001_0000) $display("FAIL %s post_idle got %b want 00010000", tag, obs_v);
    else n_pass++;
  endtask

  task automatic test_full_run();
    run_full("full_run");
  endtask

  task automatic test_start_held();
    int cyc, done_at, busy_low, lw_cnt, busy_after;
    cyc = 0; done_at = 0; busy_low = 0; lw_cnt = 0; busy_after = 0;
    start = 1'b1;
    while (done_at == 0 && cyc < 1000) begin
      tick();
      cyc++;
      if (cyc == 10) start = 1'b0;
      if (!busy) busy_low++;
      if (lw) lw_cnt++;
      if (done) done_at = cyc;
    end
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (busy) busy_after++;
    end
    n_chk++;
    if (done_at !== 462) $display("FAIL held_done_latency got %0d want 462", done_at);
    else n_pass++;
    n_chk++;
    if (busy_low !== 0) $display("FAIL held_busy_gap got %0d want 0", busy_low);
    else n_pass++;
    n_chk++;
    if (lw_cnt !== 192) $display("FAIL held_weight_count got %0d want 192", lw_cnt);
    else n_pass++;
    n_chk++;
    if (busy_after !== 0) $display("FAIL held_second_run got %0d busy cycles want 0", busy_after);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 101; c++) tick();
    n_chk++;
    if ({lw, data_out} !== {1'b1, 9'd100})
      $display("FAIL midrst_position got %h want %h", {lw, data_out}, {1'b1, 9'd100});
    else n_pass++;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    n_chk++;
    if ({obs_v, mem_addr, data_out} !== {8'b0001_0000, 8'd0, 9'd0})
      $display("FAIL midrst_idle got %h want %h", {obs_v, mem_addr, data_out}, {8'b0001_0000, 8'd0, 9'd0});
    else n_pass++;
    tick();
    n_chk++;
    if (obs_v !== 8'b0001_0000) $display("FAIL midrst_no_resume got %b want 00010000", obs_v);
    else n_pass++;
    run_full("after_reset");
  endtask

  task automatic test_small();
    logic [7:0] exp_v   [8] = '{8'b1010_0000, 8'b1011_1000, 8'b1011_1000, 8'b1001_0100,
                                8'b1001_0010, 8'b1001_0011, 8'b1101_0001, 8'b0001_0000};
    logic [7:0] exp_a   [8] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [8:0] exp_d   [8] = '{9'd0, 9'd0, 9'd1, 9'd2, 9'd0, 9'd0, 9'd0, 9'd0};
    logic [24:0] e25, o25;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      e25 = {exp_v[c], exp_a[c], exp_d[c]};
      o25 = {obs_sv, s_mem_addr, s_data_out};
      n_chk++;
      if (o25 !== e25) $display("FAIL small cycle=%0d got %h want %h", c + 1, o25, e25);
      else n_pass++;
      if (c == 5 || c == 6) begin
        n_chk++;
        if ({s_res_idx, s_res_data} !== {1'(c - 5), 14'(c - 5)})
          $display("FAIL small_result cycle=%0d got %h want %h", c + 1,
                   {s_res_idx, s_res_data}, {1'(c - 5), 14'(c - 5)});
        else n_pass++;
      end
    end
  endtask

`ifdef BNN_SEQ_BACKPRESSURE_EN
  task automatic test_backpressure();
    int  cyc, exp_idx, bad_pop, bad_res, pops;
    bit  ph, seen_done;
    cyc = 0; exp_idx = 0; bad_pop = 0; bad_res = 0; pops = 0; ph = 1'b1; seen_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!seen_done && cyc < 3000) begin
      res_ready = ph;
      ph = ~ph;
      #1;
      if (pop && !res_ready) bad_pop++;
      if (pop) pops++;
      if (res_valid) begin
        if (res_idx !== 8'(exp_idx) || res_data !== 14'(exp_idx)) bad_res++;
        exp_idx++;
      end
      if (done) seen_done = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    res_ready = 1'b1;
    tick();
    tick();
    n_chk++;
    if (!seen_done) $display("FAIL bp_timeout got no done want done within 3000 cycles");
    else n_pass++;
    n_chk++;
    if (bad_pop !== 0) $display("FAIL bp_pop_gating got %0d unready pops want 0", bad_pop);
    else n_pass++;
    n_chk++;
    if (pops !== 256) $display("FAIL bp_pop_count got %0d want 256", pops);
    else n_pass++;
    n_chk++;
    if (bad_res !== 0) $display("FAIL bp_result_order got %0d bad want 0", bad_res);
    else n_pass++;
    n_chk++;
    if (exp_idx !== 256) $display("FAIL bp_result_count got %0d want 256", exp_idx);
    else n_pass++;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_run();
    test_start_held();
    test_mid_reset();
    test_small();
`ifdef BNN_SEQ_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
